adc_sample_recorder: RTL and testbench

- Sample-rate recorder: the write-side counterpart of the ROM playback path.
- Once per DAC_LR_CLK frame it captures one parallel 16-bit ADC sample into a single-port sample RAM, then can replay the recorded span in a loop.
- Sits between the ADC deserializer (BCLK domain; sample word stable at each DAC_LR_CLK rising edge) and the DAC serializer mux. It is enabled after the I2C configuration sequence completes.

---
 rtl/adc_sample_recorder.sv | 179 +++++++++++++++++
 tb/tb_adc_sample_recorder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_recorder.sv
// Frame-rate sample recorder: captures one ADC word per DAC_LR_CLK edge into a
// single-port RAM, then loops the recorded span back out to the DAC path.
module adc_sample_recorder #(
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 17196,
  parameter int DATA_W = 16
) (
  input  logic              DAC_LR_CLK,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              rec_req_i,
  input  logic              play_req_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wren_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [DATA_W-1:0] play_data_o,
  output logic              play_valid_o,
  output logic [ADDR_W-1:0] rec_len_o,
  output logic              full_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_e state_q, state_d;

  logic              recPrev_q, playPrev_q;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic              memWren_q, memWren_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic [DATA_W-1:0] playData_q, playData_d;
  logic              playValid_q, playValid_d;
  logic [1:0]        issue_q, issue_d;
  logic [ADDR_W-1:0] recLen_q, recLen_d;
  logic              full_q, full_d;

  logic recRise, playRise;

  assign recRise  = rec_req_i & ~recPrev_q;
  assign playRise = play_req_i & ~playPrev_q;

  always_ff @(posedge DAC_LR_CLK) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (recRise) begin
            state_d = RECORD;
          end else if (playRise && (recLen_q != '0)) begin
            state_d = PLAY;
          end
        end
        RECORD: begin
          if (!rec_req_i || (wrPtr_q == LAST_ADDR)) begin
            state_d = IDLE;
          end
        end
        PLAY: begin
          if (!play_req_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read issue flag travels two stages to line up with the RAM's registered read.
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    memAddr_d   = memAddr_q;
    memWren_d   = 1'b0;
    memWdata_d  = memWdata_q;
    recLen_d    = recLen_q;
    full_d      = full_q;
    issue_d     = {issue_q[0], 1'b0};
    playValid_d = issue_q[1];
    playData_d  = issue_q[1] ? mem_rdata_i : playData_q;
    if (!enable_i) begin
      issue_d     = 2'b00;
      playValid_d = 1'b0;
      playData_d  = playData_q;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (recRise) begin
            wrPtr_d  = '0;
            full_d   = 1'b0;
            recLen_d = '0;
          end else if (playRise && (recLen_q != '0)) begin
            rdPtr_d = '0;
          end
        end
        RECORD: begin
          if (rec_req_i) begin
            memAddr_d  = wrPtr_q;
            memWdata_d = adc_data_i;
            memWren_d  = 1'b1;
            wrPtr_d    = wrPtr_q + ONE;
            recLen_d   = wrPtr_q + ONE;
            if (wrPtr_q == LAST_ADDR) begin
              full_d = 1'b1;
            end
          end
        end
        PLAY: begin
          if (play_req_i) begin
            memAddr_d  = rdPtr_q;
            issue_d[0] = 1'b1;
            rdPtr_d    = (rdPtr_q == recLen_q - ONE) ? '0 : rdPtr_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge DAC_LR_CLK) begin
    if (!reset) begin
      recPrev_q   <= 1'b0;
      playPrev_q  <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      memAddr_q   <= '0;
      memWren_q   <= 1'b0;
      memWdata_q  <= '0;
      playData_q  <= '0;
      playValid_q <= 1'b0;
      issue_q     <= 2'b00;
      recLen_q    <= '0;
      full_q      <= 1'b0;
    end else begin
      recPrev_q   <= rec_req_i;
      playPrev_q  <= play_req_i;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      memAddr_q   <= memAddr_d;
      memWren_q   <= memWren_d;
      memWdata_q  <= memWdata_d;
      playData_q  <= playData_d;
      playValid_q <= playValid_d;
      issue_q     <= issue_d;
      recLen_q    <= recLen_d;
      full_q      <= full_d;
    end
  end

  assign mem_addr_o   = memAddr_q;
  assign mem_wren_o   = memWren_q;
  assign mem_wdata_o  = memWdata_q;
  assign play_data_o  = playData_q;
  assign play_valid_o = playValid_q;
  assign rec_len_o    = recLen_q;
  assign full_o       = full_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_adc_sample_recorder.sv
// Randomised scoreboard bench for adc_sample_recorder with a behavioural
// record/loop-playback model and a registered-read RAM next to the DUT.
module tb_adc_sample_recorder;

  localparam int ADDR_W = 18;
  localparam int DEPTH  = 12;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [1:0]        st;
    logic [ADDR_W-1:0] len;
    logic              full;
    logic              wren;
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] pdata;
  } cyc_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              recReq;
  logic              playReq;
  logic [DATA_W-1:0] adcData;
  logic [DATA_W-1:0] memRdata;
  logic [ADDR_W-1:0] memAddr;
  logic              memWren;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] playData;
  logic              playValid;
  logic [ADDR_W-1:0] recLen;
  logic              full;
  logic [1:0]        state;

  int errors = 0;
  int checks = 0;

  cyc_t              expCycQ[$];
  wr_t               expWrQ[$];
  logic [DATA_W-1:0] expPlayQ[$];

  always #5 clk = ~clk;

  adc_sample_recorder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .DAC_LR_CLK  (clk),
    .reset       (reset),
    .enable_i    (enable),
    .rec_req_i   (recReq),
    .play_req_i  (playReq),
    .adc_data_i  (adcData),
    .mem_rdata_i (memRdata),
    .mem_addr_o  (memAddr),
    .mem_wren_o  (memWren),
    .mem_wdata_o (memWdata),
    .play_data_o (playData),
    .play_valid_o(playValid),
    .rec_len_o   (recLen),
    .full_o      (full),
    .state_o     (state)
  );

  // Single-port sample RAM with a registered read port
  logic [DATA_W-1:0] ram [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    memRdata = '0;
  end
  always @(posedge clk) begin
    if (memAddr < DEPTH) begin
      if (memWren) ram[memAddr] <= memWdata;
      memRdata <= ram[memAddr];
    end
  end

  // Behavioural model: a recording is a list of samples, playback walks it
  // modulo its length, and each read surfaces two frames after it is issued.
  int mState, mRecLen, mWp, mPlayCount, mAddr, mPdata;
  bit mFull, mWren, mValid, mPrevRec, mPrevPlay;
  int recorded[DEPTH];
  int pipeQ[$];

  task automatic modelStep(input bit rstN, input bit en, input bit rec, input bit play,
                           input int adc);
    int  e;
    int  issued;
    bit  recRise, playRise;
    cyc_t c;
    issued = -1;
    if (!rstN) begin
      mState = 0; mRecLen = 0; mWp = 0; mPlayCount = 0; mAddr = 0; mPdata = 0;
      mFull = 0; mWren = 0; mValid = 0; mPrevRec = 0; mPrevPlay = 0;
      pipeQ = {-1, -1};
    end else begin
      recRise  = rec && !mPrevRec;
      playRise = play && !mPrevPlay;
      mWren = 0;
      if (en) begin
        e = pipeQ.pop_front();
        mValid = (e >= 0);
        if (e >= 0) begin
          mPdata = recorded[e];
          expPlayQ.push_back(DATA_W'(recorded[e]));
        end
      end else begin
        mValid = 0;
        pipeQ.delete();
        pipeQ.push_back(-1);
      end
      if (!en) begin
        mState = 0;
      end else if (mState == 0) begin
        if (recRise) begin
          mState = 1; mWp = 0; mFull = 0; mRecLen = 0;
        end else if (playRise && mRecLen > 0) begin
          mState = 2; mPlayCount = 0;
        end
      end else if (mState == 1) begin
        if (rec) begin
          recorded[mWp] = adc;
          mAddr = mWp;
          mWren = 1;
          expWrQ.push_back('{addr: ADDR_W'(mWp), data: DATA_W'(adc)});
          mRecLen = mWp + 1;
          if (mWp == DEPTH - 1) begin
            mFull = 1;
            mState = 0;
          end
          mWp++;
        end else begin
          mState = 0;
        end
      end else begin
        if (play) begin
          issued = mPlayCount % mRecLen;
          mAddr = issued;
          mPlayCount++;
        end else begin
          mState = 0;
        end
      end
      pipeQ.push_back(issued);
      mPrevRec = rec;
      mPrevPlay = play;
    end
    c.st = 2'(mState); c.len = ADDR_W'(mRecLen); c.full = mFull; c.wren = mWren;
    c.valid = mValid; c.addr = ADDR_W'(mAddr); c.pdata = DATA_W'(mPdata);
    expCycQ.push_back(c);
  endtask

  task automatic applyStimulus(input bit rstN, input bit en, input bit rec, input bit play,
                               input int adc);
    reset   = rstN;
    enable  = en;
    recReq  = rec;
    playReq = play;
    adcData = DATA_W'(adc);
    modelStep(rstN, en, rec, play, adc);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 0, 0, $urandom_range(0, 65535));
  endtask

  // Monitor: compares one cycle expectation per edge, plus write and playback scoreboards
  initial begin
    cyc_t act, exp;
    wr_t  wAct, wExp;
    logic [DATA_W-1:0] pExp;
    forever begin
      @(posedge clk);
      #1;
      if (expCycQ.size() > 0) begin
        exp = expCycQ.pop_front();
        act.st = state; act.len = recLen; act.full = full; act.wren = memWren;
        act.valid = playValid; act.addr = memAddr; act.pdata = playData;
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL cycle t=%0t: got st=%0d len=%0d full=%0b wren=%0b vld=%0b addr=%0d pdata=%h; expected st=%0d len=%0d full=%0b wren=%0b vld=%0b addr=%0d pdata=%h",
                   $time, act.st, act.len, act.full, act.wren, act.valid, act.addr, act.pdata,
                   exp.st, exp.len, exp.full, exp.wren, exp.valid, exp.addr, exp.pdata);
        end
        if (memWren === 1'b1) begin
          checks++;
          wAct = '{addr: memAddr, data: memWdata};
          if (expWrQ.size() == 0) begin
            errors++;
            $display("FAIL write t=%0t: got addr=%0d data=%h, expected no write", $time, memAddr, memWdata);
          end else begin
            wExp = expWrQ.pop_front();
            if (wAct !== wExp) begin
              errors++;
              $display("FAIL write t=%0t: got addr=%0d data=%h, expected addr=%0d data=%h",
                       $time, wAct.addr, wAct.data, wExp.addr, wExp.data);
            end
          end
        end
        if (playValid === 1'b1) begin
          checks++;
          if (expPlayQ.size() == 0) begin
            errors++;
            $display("FAIL play t=%0t: got %h, expected no sample", $time, playData);
          end else begin
            pExp = expPlayQ.pop_front();
            if (playData !== pExp) begin
              errors++;
              $display("FAIL play t=%0t: got %h, expected %h", $time, playData, pExp);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit rec, play, en, rstN;
    $display("[TB] start");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    idle(2);

    // Reset asserted for three frames in the middle of a recording
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 1, 0, $urandom_range(0, 65535));
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, $urandom_range(0, 65535));
    idle(3);

    // Ten-sample recording of 0x1000..0x1009
    applyStimulus(1, 1, 1, 0, 'hFFFF);
    for (int n = 0; n < 10; n++) applyStimulus(1, 1, 1, 0, 'h1000 + n);
    idle(3);

    // Loop playback for 25 issued addresses
    for (int i = 0; i < 26; i++) applyStimulus(1, 1, 0, 1, 0);
    idle(5);

    // Capacity stop with request still high
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 1, 0, $urandom_range(0, 65535));
    idle(3);
    for (int i = 0; i < 15; i++) applyStimulus(1, 1, 0, 1, 0);
    idle(4);

    // Simultaneous rises, then play toggling during the recording
    applyStimulus(1, 1, 1, 1, $urandom_range(0, 65535));
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 1, i[0], $urandom_range(0, 65535));
    idle(4);

    // Play with an empty recording
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 0, 0);
    idle(1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 1, 0);
    idle(2);

    // Enable dropped mid-playback, play level held through it
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, 1, 0, $urandom_range(0, 65535));
    idle(2);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1, 0);
    idle(3);

    // Random switch activity
    rec = 0; play = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) rec = ~rec;
      if ($urandom_range(0, 7) == 0) play = ~play;
      en   = ($urandom_range(0, 31) != 0);
      rstN = ($urandom_range(0, 199) != 0);
      applyStimulus(rstN, en, rec, play, $urandom_range(0, 65535));
    end
    idle(4);
    @(negedge clk);

    checks++;
    if (expCycQ.size() != 0 || expWrQ.size() != 0 || expPlayQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got cyc=%0d wr=%0d play=%0d pending, expected 0",
               expCycQ.size(), expWrQ.size(), expPlayQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
